// File: rtl/uart_fifo_param.sv
// Parameterised synchronous FIFO with selectable first-word-fall-through or registered read,
// occupancy/threshold status and sticky overflow/underflow flags.
module uart_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic [$clog2(DEPTH):0]  trig_level,
    input  logic                    err_clr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    thr_trig,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wa, ra;

    // A write into a full FIFO is legal only when a read frees the slot in the same cycle.
    assign wa = wr_en & ~flush & (~full | rd_en);
    assign ra = rd_en & ~flush & ~empty;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= DEPTH_C - 1'b1);
    assign almost_empty = (count_q <= (AW+1)'(1));
    assign thr_trig     = (trig_level != '0) && (count_q >= trig_level);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = (wr_en & full & ~rd_en & ~flush) | (overflow_q & ~err_clr);
        underflow_d = (rd_en & empty & ~flush) | (underflow_q & ~err_clr);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wa) wr_ptr_d = wr_ptr_q + AW'(1);
            if (ra) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wa, ra})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wa) mem_q[wr_ptr_q] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem_q[rd_ptr_q];
            assign rd_valid = ~empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= ra;
                    if (ra) rd_data_q <= mem_q[rd_ptr_q];
                end
            end
            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed plus random bench for uart_fifo_param; drives an FWFT and a registered-read
// instance with the same stimulus and checks both against a queue model.
module tb_uart_fifo_param;
    logic       clk;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [4:0] trig_level;
    logic       err_clr;

    logic [7:0] rd_data, r_rd_data;
    logic       rd_valid, r_rd_valid;
    logic [4:0] count, r_count;
    logic       full, empty, almost_full, almost_empty, thr_trig, overflow, underflow;
    logic       r_full, r_empty, r_almost_full, r_almost_empty, r_thr_trig, r_overflow, r_underflow;

    logic [7:0] exp_q[$];
    logic       ovf_m, unf_m, rv_m;
    logic [7:0] rdat_m;
    int         checks;
    int         failures;

    uart_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .trig_level(trig_level),
        .err_clr(err_clr), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .thr_trig(thr_trig),
        .overflow(overflow), .underflow(underflow)
    );

    uart_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) dut_r (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(r_rd_data), .rd_valid(r_rd_valid), .trig_level(trig_level),
        .err_clr(err_clr), .count(r_count), .full(r_full), .empty(r_empty),
        .almost_full(r_almost_full), .almost_empty(r_almost_empty), .thr_trig(r_thr_trig),
        .overflow(r_overflow), .underflow(r_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        int n;
        n = exp_q.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == 16));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= 15));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
        chk("thr_trig", 32'(thr_trig), 32'((trig_level != 0) && (n >= int'(trig_level))));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("underflow", 32'(underflow), 32'(unf_m));
        chk("fwft_rd_valid", 32'(rd_valid), 32'(n != 0));
        if (n != 0) chk("fwft_head", 32'(rd_data), 32'(exp_q[0]));
        chk("reg_count", 32'(r_count), 32'(n));
        chk("reg_rd_valid", 32'(r_rd_valid), 32'(rv_m));
        chk("reg_rd_data", 32'(r_rd_data), 32'(rdat_m));
    endtask

    // One clock of stimulus, entered and left at a falling edge.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                        input logic fl, input logic ec);
        logic full_m, empty_m, wa, ra;
        logic [7:0] exp_rd;
        wr_en = wr; wr_data = d; rd_en = rd; flush = fl; err_clr = ec;
        full_m  = (exp_q.size() == 16);
        empty_m = (exp_q.size() == 0);
        wa = wr && !fl && (!full_m || rd);
        ra = rd && !fl && !empty_m;
        exp_rd = 8'h00;
        #1;
        if (ra) begin
            exp_rd = exp_q[0];
            chk("fwft_rd_data", 32'(rd_data), 32'(exp_rd));
        end
        ovf_m = (wr && full_m && !rd && !fl) || (ovf_m && !ec);
        unf_m = (rd && empty_m && !fl) || (unf_m && !ec);
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
        else begin
            if (ra) void'(exp_q.pop_front());
            if (wa) exp_q.push_back(d);
        end
        rv_m = ra;
        if (ra) rdat_m = exp_rd;
        check_status();
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        ovf_m = 1'b0; unf_m = 1'b0; rv_m = 1'b0; rdat_m = 8'h00;
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
        trig_level = 5'd0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        check_status();
        rst = 1'b0;
        @(negedge clk);

        // Fill, overflow attempt, drain in order.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Underflow, clear, and set-wins-over-clear.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Empty with simultaneous read and write: write only.
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Full with sustained read+write across pointer wrap.
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Threshold trigger and its combinational disable.
        trig_level = 5'd8;
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        trig_level = 5'd0;
        #1;
        chk("thr_off_comb", 32'(thr_trig), 32'(0));
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Read latency for both read styles.
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush with pending write; sticky underflow must survive.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hC3;
        #2 rst = 1'b1;
        #1;
        exp_q.delete(); ovf_m = 1'b0; unf_m = 1'b0; rv_m = 1'b0; rdat_m = 8'h00;
        check_status();
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'hB7, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Random traffic.
        trig_level = 5'd5;
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_fifo_param.md
UART_FIFO_PARAM -- requirements
Module: uart_fifo_param

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the word width in bits (1..32).
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning the entry count; it is a power of two, >=2. AW = log2(DEPTH).
REQ-003 The module SHALL have parameter FWFT, default 1; 1 = first-word-fall-through read, 0 = registered read.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous clear of FIFO contents.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  DATA_WIDTH  write word.
REQ-009 rd_en  input  1  read request.
REQ-010 rd_data  output  DATA_WIDTH  read word.
REQ-011 rd_valid  output  1  rd_data qualifier.
REQ-012 trig_level  input  AW+1  threshold for thr_trig; 0 disables.
REQ-013 err_clr  input  1  clears sticky error flags.
REQ-014 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-015 full, empty, almost_full, almost_empty, thr_trig  output  1 each  status.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Write accept wa = wr_en & ~flush & (~full | rd_en); read accept ra = rd_en & ~flush & ~empty.
REQ-018 Empty with wr_en=rd_en=1: write only accepted, no bypass; count +1.
REQ-019 Full with wr_en=rd_en=1: both accepted; count unchanged; pointers each +1; full stays 1.
REQ-020 Pointers SHALL be AW bits and wrap modulo DEPTH with no gap or stall at wrap.
REQ-021 count: +1 on wa only, -1 on ra only, unchanged on both or neither; it never exceeds DEPTH nor goes below 0.
REQ-022 Status SHALL be registered or derived from registered count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=DEPTH-1), almost_empty=(count<=1).
REQ-023 thr_trig SHALL be (trig_level!=0) & (count>=trig_level) and reflect a trig_level change combinationally.
REQ-024 FWFT=1: rd_data SHALL equal mem[rd_ptr] combinationally, and rd_valid SHALL be ~empty.
REQ-025 FWFT=0: on ra, rd_data SHALL register mem[rd_ptr] at that edge, and rd_valid SHALL pulse 1 for one cycle; otherwise rd_valid=0 and rd_data holds.
REQ-026 Memory write SHALL occur at mem[wr_ptr] on wa only; a rejected write leaves memory unchanged.
REQ-027 overflow SHALL be set on the edge where wr_en & full & ~rd_en & ~flush.
REQ-028 underflow SHALL be set on the edge where rd_en & empty & ~flush.
REQ-029 Sticky flags SHALL clear on err_clr; if set and clear occur in the same cycle, set wins.
REQ-030 flush SHALL take priority over wr_en/rd_en: pointers and count go to 0 next edge; error flags and memory are unaffected; FWFT=0 rd_valid is 0 that cycle.
REQ-031 Throughput SHALL be one write and one read per cycle sustained, with no bubbles.

Reset
REQ-032 During rst: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, thr_trig=0, overflow=0, underflow=0, rd_valid=0 (FWFT=0), rd_data=0 (FWFT=0).
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 rst asserted mid-traffic SHALL abort all in-flight operations; the first edge after deassertion SHALL behave as from an empty FIFO.

Verification (DATA_WIDTH=8, DEPTH=16)
REQ-035 Write 0x00..0x0F, then 1 more write (0xAA) -> full=1 and count=16 after 16th; 0xAA dropped; overflow=1; reads return 0x00..0x0F in order.
REQ-036 At empty, rd_en 1 cycle -> underflow=1, count=0; then err_clr -> underflow=0 next edge; err_clr with rd_en on empty -> underflow stays 1.
REQ-037 Fill to 16, then 20 cycles of wr_en=rd_en=1 -> count stays 16, no overflow, output sequence continuous across pointer wrap.
REQ-038 trig_level=8: after 7 writes thr_trig=0; 8th write -> thr_trig=1; trig_level=0 -> thr_trig=0 immediately.
REQ-039 FWFT=0: write 0x5A, then rd_en -> rd_valid=1 with rd_data=0x5A exactly one cycle after the read edge; FWFT=1 -> rd_data=0x5A the cycle after the write.
REQ-040 With 5 entries, flush together with wr_en=1 -> count=0, empty=1 next edge; write dropped; overflow/underflow unchanged.
